// File: rtl/regfile_write_arbiter.sv
// Regfile write arbiter: merges pipeline writeback, rstatus (r30) writes and
// multdiv completions onto a single registered regfile write port. Multdiv
// results wait in a 2-entry FIFO and an age counter forces a stall when the
// head has waited too long.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        wb_status_valid,
  input  logic [31:0] wb_status_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall
);

  localparam logic [4:0]  StatusReg = 5'd30;
  localparam logic [31:0] ExceptionCode = 32'd1;
  localparam logic [1:0]  AgeMax = 2'd3;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    STATUS   = 2'd1,
    MD_FORCE = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exception;
  } mdEntry_t;

  state_e      state_q, state_d;
  mdEntry_t    slot0_q, slot1_q;
  logic [1:0]  count_q, count_d;
  logic [1:0]  age_q, age_d;
  logic [31:0] statusHeld_q, statusHeld_d;

  logic        writeEnable_q;
  logic [4:0]  writeReg_q;
  logic [31:0] writeData_q;
  logic        stall_q;

  logic        sel;
  logic [4:0]  selReg;
  logic [31:0] selData;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        pushToSlot0;
  logic [4:0]  headReg;
  logic [31:0] headData;
  logic        mdReg;
  logic [4:0]  mdBypassReg;
  logic [31:0] mdBypassData;
  mdEntry_t    newEntry;

  assign md_ready = (count_q < 2'd2);

  // An exception entry turns into a write of code 1 to rstatus.
  assign headReg      = slot0_q.exception ? StatusReg : slot0_q.rd;
  assign headData     = slot0_q.exception ? ExceptionCode : slot0_q.data;
  assign mdReg        = md_exception;
  assign mdBypassReg  = mdReg ? StatusReg : md_rd;
  assign mdBypassData = mdReg ? ExceptionCode : md_data;
  assign newEntry     = '{rd: md_rd, data: md_data, exception: md_exception};

  // Choose this cycle's write source and the next arbiter state.
  always_comb begin
    state_d      = state_q;
    statusHeld_d = statusHeld_q;
    sel          = 1'b0;
    selReg       = '0;
    selData      = '0;
    pop          = 1'b0;
    bypass       = 1'b0;
    unique case (state_q)
      STATUS: begin
        sel     = 1'b1;
        selReg  = StatusReg;
        selData = statusHeld_q;
        state_d = (age_q == AgeMax) ? MD_FORCE : NORMAL;
      end
      MD_FORCE: begin
        if (count_q != 2'd0) begin
          sel     = 1'b1;
          pop     = 1'b1;
          selReg  = headReg;
          selData = headData;
        end
        state_d = NORMAL;
      end
      default: begin
        state_d = NORMAL;
        if (wb_valid) begin
          sel     = 1'b1;
          selReg  = wb_rd;
          selData = wb_data;
          if (wb_status_valid) begin
            statusHeld_d = wb_status_data;
            state_d      = STATUS;
          end
        end else if (wb_status_valid) begin
          sel     = 1'b1;
          selReg  = StatusReg;
          selData = wb_status_data;
        end else if (count_q != 2'd0) begin
          sel     = 1'b1;
          pop     = 1'b1;
          selReg  = headReg;
          selData = headData;
        end else if (md_valid) begin
          sel     = 1'b1;
          bypass  = 1'b1;
          selReg  = mdBypassReg;
          selData = mdBypassData;
        end
        if ((state_d == NORMAL) && (age_q == AgeMax) && !pop) begin
          state_d = MD_FORCE;
        end
      end
    endcase
  end

  // FIFO occupancy and head-age bookkeeping.
  always_comb begin
    push        = md_valid && md_ready && !bypass;
    pushToSlot0 = (count_q == 2'd0) || pop;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    if (pop || (count_q == 2'd0)) begin
      age_d = 2'd0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + 2'd1;
    end else begin
      age_d = age_q;
    end
  end

  // Arbiter state, counters and the held status word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= NORMAL;
      count_q      <= 2'd0;
      age_q        <= 2'd0;
      statusHeld_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      age_q        <= age_d;
      statusHeld_q <= statusHeld_d;
    end
  end

  // Shift-style FIFO storage; a push in the same cycle as a pop lands in the head slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      if (pop) begin
        slot0_q <= slot1_q;
      end
      if (push) begin
        if (pushToSlot0) begin
          slot0_q <= newEntry;
        end else begin
          slot1_q <= newEntry;
        end
      end
    end
  end

  // Registered write port; register and data hold when nothing is selected.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writeEnable_q <= 1'b0;
      writeReg_q    <= '0;
      writeData_q   <= '0;
      stall_q       <= 1'b0;
    end else begin
      writeEnable_q <= sel && (selReg != 5'd0);
      if (sel) begin
        writeReg_q  <= selReg;
        writeData_q <= selData;
      end
      stall_q <= (state_d != NORMAL);
    end
  end

  assign ctrl_writeEnable = writeEnable_q;
  assign ctrl_writeReg    = writeReg_q;
  assign data_writeReg    = writeData_q;
  assign stall            = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_status_valid;
  logic [31:0] wb_status_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall;

  int checkCount = 0;
  int errorCount = 0;

  regfile_write_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_status_valid (wb_status_valid),
    .wb_status_data  (wb_status_data),
    .md_valid        (md_valid),
    .md_rd           (md_rd),
    .md_data         (md_data),
    .md_exception    (md_exception),
    .md_ready        (md_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .stall           (stall)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: pending multdiv results in a queue, a waiting-time count,
  // and flags for the one-cycle status and forced-drain follow-ups.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } mdItem_t;

  mdItem_t     modelQueue[$];
  int          waitCycles;
  bit          statusPending;
  bit          forcePending;
  logic [31:0] heldStatus;
  logic        expWe;
  logic [4:0]  expReg;
  logic [31:0] expData;
  logic        expStall;
  bit          regKnown;

  bit          served, takeHead, bypassMd, acceptMd, nextStatus, nextForce;
  logic [4:0]  wr;
  logic [31:0] wd;
  int          sizeBefore;
  mdItem_t     headItem;

  // Advance the model on each rising edge using the inputs that edge samples.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      modelQueue.delete();
      waitCycles    = 0;
      statusPending = 0;
      forcePending  = 0;
      heldStatus    = '0;
      expWe         = 1'b0;
      expReg        = '0;
      expData       = '0;
      expStall      = 1'b0;
      regKnown      = 1;
    end else begin
      served     = 0;
      takeHead   = 0;
      bypassMd   = 0;
      nextStatus = 0;
      nextForce  = 0;
      wr         = '0;
      wd         = '0;
      sizeBefore = modelQueue.size();
      acceptMd   = md_valid && (sizeBefore < 2);
      if (statusPending) begin
        served    = 1;
        wr        = 5'd30;
        wd        = heldStatus;
        nextForce = (waitCycles == 3);
      end else if (forcePending) begin
        takeHead = (sizeBefore > 0);
      end else begin
        if (wb_valid) begin
          served = 1;
          wr     = wb_rd;
          wd     = wb_data;
          if (wb_status_valid) begin
            heldStatus = wb_status_data;
            nextStatus = 1;
          end
        end else if (wb_status_valid) begin
          served = 1;
          wr     = 5'd30;
          wd     = wb_status_data;
        end else if (sizeBefore > 0) begin
          takeHead = 1;
        end else if (md_valid) begin
          bypassMd = 1;
          served   = 1;
          wr       = md_exception ? 5'd30 : md_rd;
          wd       = md_exception ? 32'd1 : md_data;
        end
        if (!nextStatus && (waitCycles == 3) && !takeHead) nextForce = 1;
      end
      if (takeHead) begin
        headItem = modelQueue.pop_front();
        served   = 1;
        wr       = headItem.exc ? 5'd30 : headItem.rd;
        wd       = headItem.exc ? 32'd1 : headItem.data;
      end
      if (takeHead || (sizeBefore == 0)) waitCycles = 0;
      else if (waitCycles < 3) waitCycles = waitCycles + 1;
      if (acceptMd && !bypassMd) modelQueue.push_back('{md_rd, md_data, md_exception});
      expWe = served && (wr != 5'd0);
      if (served) begin
        expReg   = wr;
        expData  = wd;
        regKnown = (wr != 5'd0);
      end
      statusPending = nextStatus;
      forcePending  = nextForce;
      expStall      = nextStatus || nextForce;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clock) begin
    checkOutput("modelWe", ctrl_writeEnable, expWe);
    checkOutput("modelStall", stall, expStall);
    checkOutput("modelReady", md_ready, (modelQueue.size() < 2));
    if (regKnown) begin
      checkOutput("modelReg", ctrl_writeReg, expReg);
      checkOutput("modelData", data_writeReg, expData);
    end
  end

  task automatic applyStimulus(input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
                               input logic stV, input logic [31:0] stD,
                               input logic mdV, input logic [4:0] mdR, input logic [31:0] mdD,
                               input logic mdE);
    wb_valid        = wbV;
    wb_rd           = wbR;
    wb_data         = wbD;
    wb_status_valid = stV;
    wb_status_data  = stD;
    md_valid        = mdV;
    md_rd           = mdR;
    md_data         = mdD;
    md_exception    = mdE;
    @(negedge clock);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 5'd0, 32'd0, 0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  // Time limit so the run always reaches the summary line.
  initial begin
    #200000;
    errorCount++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Directed scenarios.
  initial begin
    reset = 1'b0;
    wb_valid = 0; wb_rd = '0; wb_data = '0; wb_status_valid = 0; wb_status_data = '0;
    md_valid = 0; md_rd = '0; md_data = '0; md_exception = 0;
    @(negedge clock);
    checkOutput("resetWe", ctrl_writeEnable, 0);
    checkOutput("resetReg", ctrl_writeReg, 0);
    checkOutput("resetData", data_writeReg, 0);
    checkOutput("resetStall", stall, 0);
    checkOutput("resetReady", md_ready, 1);
    reset = 1'b1;

    // Plain writeback.
    applyStimulus(1, 5'd5, 32'hA5, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    checkOutput("wbWe", ctrl_writeEnable, 1);
    checkOutput("wbReg", ctrl_writeReg, 5);
    checkOutput("wbData", data_writeReg, 32'hA5);
    checkOutput("wbStall", stall, 0);

    // Writeback plus status from the same instruction.
    applyStimulus(1, 5'd3, 32'd7, 1, 32'd2, 0, 5'd0, 32'd0, 0);
    checkOutput("dualReg", ctrl_writeReg, 3);
    checkOutput("dualData", data_writeReg, 7);
    checkOutput("dualStall", stall, 1);
    idleCycle();
    checkOutput("statusWe", ctrl_writeEnable, 1);
    checkOutput("statusReg", ctrl_writeReg, 30);
    checkOutput("statusData", data_writeReg, 2);
    checkOutput("statusStall", stall, 0);
    idleCycle();
    checkOutput("idleWe", ctrl_writeEnable, 0);
    checkOutput("idleHoldReg", ctrl_writeReg, 30);

    // Multdiv exception bypass on an idle pipeline.
    applyStimulus(0, 5'd0, 32'd0, 0, 32'd0, 1, 5'd9, 32'h99, 1);
    checkOutput("excWe", ctrl_writeEnable, 1);
    checkOutput("excReg", ctrl_writeReg, 30);
    checkOutput("excData", data_writeReg, 1);
    idleCycle();

    // Register 0 targets.
    applyStimulus(1, 5'd0, 32'h1234, 0, 32'd0, 0, 5'd0, 32'd0, 0);
    checkOutput("r0WbWe", ctrl_writeEnable, 0);
    applyStimulus(1, 5'd4, 32'h44, 0, 32'd0, 1, 5'd0, 32'h55, 0);
    checkOutput("r0QueueWbReg", ctrl_writeReg, 4);
    idleCycle();
    checkOutput("r0PopWe", ctrl_writeEnable, 0);
    checkOutput("r0PopReady", md_ready, 1);
    idleCycle();

    // Multdiv backlog under continuous writeback forces drain stalls.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 5'(10 + i), 32'(200 + i), 0, 32'd0, (i < 3), 5'd8, 32'(100 + i), 0);
      if (i == 1) checkOutput("backlogReady", md_ready, 0);
      if (i == 4) checkOutput("forceStall1", stall, 1);
      if (i == 5) begin
        checkOutput("forceReg1", ctrl_writeReg, 8);
        checkOutput("forceData1", data_writeReg, 100);
        checkOutput("forceEnd1", stall, 0);
      end
      if (i == 9) checkOutput("forceStall2", stall, 1);
      if (i == 10) begin
        checkOutput("forceReg2", ctrl_writeReg, 8);
        checkOutput("forceData2", data_writeReg, 101);
      end
    end

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 24; i++) begin
      applyStimulus((i % 3) == 0, 5'(i % 4), 32'(i * 17), (i % 5) == 1, 32'(i + 1000),
                    (i % 2) == 0, 5'(i % 6), 32'(i * 3 + 7), (i % 7) == 3);
    end
    for (int i = 0; i < 10; i++) idleCycle();

    // Reset in the middle of a backlog with a status write pending.
    applyStimulus(1, 5'd11, 32'd11, 0, 32'd0, 1, 5'd12, 32'd12, 0);
    applyStimulus(1, 5'd13, 32'd13, 1, 32'd77, 1, 5'd14, 32'd14, 0);
    checkOutput("preResetReady", md_ready, 0);
    checkOutput("preResetStall", stall, 1);
    wb_valid = 0; wb_status_valid = 0; md_valid = 0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midResetWe", ctrl_writeEnable, 0);
    checkOutput("midResetReg", ctrl_writeReg, 0);
    checkOutput("midResetData", data_writeReg, 0);
    checkOutput("midResetStall", stall, 0);
    checkOutput("midResetReady", md_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("postResetWe", ctrl_writeEnable, 0);
      checkOutput("postResetStall", stall, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
